amm_arbiter: RTL and testbench

Single-clock Avalon-MM arbiter that shares one downstream slave port between M_CNT upstream masters. It grants one transaction at a time, forwards the winner's command to the slave, and steers read responses back to the issuing master through an ID FIFO of outstanding reads. It sits between the masters and the slave side of an amm_cdc, or any other single amm_if slave, on the same clock domain.

---
 rtl/amm_arb_pkg.sv | 15 +
 rtl/amm_if.sv | 27 ++
 rtl/amm_arb_id_fifo.sv | 52 +++++
 rtl/amm_arbiter.sv | 145 ++++++++++++++
 tb/tb_amm_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/amm_arb_pkg.sv
// amm_arb_pkg: shared types and helpers for the Avalon-MM arbiter.
//   id_width()  - bits needed to name one of n masters (minimum 1)
//   arb_state_t - arbiter FSM state
package amm_arb_pkg;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/amm_if.sv
// amm_if: Avalon-MM command/response bundle.
//   master modport - drives command (address, byteenable, writedata, read, write),
//                    receives waitrequest, readdata, readdatavalid
//   slave modport  - the mirror image
interface amm_if #(
  parameter int unsigned A_W = 32,
  parameter int unsigned D_W = 64
) ();
  logic [A_W-1:0]   address;
  logic [D_W/8-1:0] byteenable;
  logic [D_W-1:0]   writedata;
  logic             read;
  logic             write;
  logic             waitrequest;
  logic [D_W-1:0]   readdata;
  logic             readdatavalid;

  modport master (
    output address, byteenable, writedata, read, write,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, writedata, read, write,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/amm_arb_id_fifo.sv
// amm_arb_id_fifo: register-based synchronous FIFO holding the master ID of each
// outstanding read, in issue order.
//   clk_i, rst_i - clock, synchronous active-high reset (clears pointers/count)
//   push, din    - enqueue din (ignored when full)
//   pop, dout    - dequeue head; dout is the current head (ignored when empty)
//   full, empty  - occupancy flags
module amm_arb_id_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned ID_W  = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push,
  input  logic            pop,
  input  logic [ID_W-1:0] din,
  output logic [ID_W-1:0] dout,
  output logic            full,
  output logic            empty
);
  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [ID_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   cnt_q;
  logic            do_push, do_pop;

  assign full    = (cnt_q == (PtrW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/amm_arbiter.sv
// amm_arbiter: shares one Avalon-MM slave between M_CNT masters, one transaction
// at a time. Read responses are steered back through a FIFO of issuing IDs.
//   clk_i, rst_i - clock, synchronous active-high reset
//   amm_if_m[]   - upstream masters (this block is their slave)
//   amm_if_s     - downstream slave (this block is its master)
//   err_o        - sticky: readdatavalid arrived with no read outstanding
// Build option: define AMM_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise fixed priority with the lowest index winning.
module amm_arbiter
  import amm_arb_pkg::*;
#(
  parameter int unsigned M_CNT  = 2,
  parameter int unsigned A_W    = 32,
  parameter int unsigned D_W    = 64,
  parameter int unsigned MAX_RD = 8
) (
  input  logic  clk_i,
  input  logic  rst_i,
  amm_if.slave  amm_if_m [M_CNT],
  amm_if.master amm_if_s,
  output logic  err_o
);
  localparam int unsigned IdW = id_width(M_CNT);

  logic [M_CNT-1:0] m_read, m_write, eligible;
  logic [A_W-1:0]   m_addr  [M_CNT];
  logic [D_W/8-1:0] m_be    [M_CNT];
  logic [D_W-1:0]   m_wdata [M_CNT];

  arb_state_t       state_q, state_d;
  logic [IdW-1:0]   gnt_id_q, gnt_id_d, winner, search_start;
  logic             granted, accept, push, rsp_valid, err_q;
  logic             fifo_full, fifo_empty;
  logic [IdW-1:0]   fifo_dout;

  // First eligible requester at or after start, wrapping modulo M_CNT.
  function automatic logic [IdW-1:0] pick_winner(input logic [M_CNT-1:0] elig,
                                                 input logic [IdW-1:0]   start);
    logic [IdW-1:0] win;
    logic [IdW-1:0] idx;
    logic           found;
    win   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < M_CNT; i++) begin
      idx = IdW'((int'(start) + i) % M_CNT);
      if (!found && elig[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  for (genvar k = 0; k < M_CNT; k++) begin : g_master
    assign m_read[k]  = amm_if_m[k].read;
    assign m_write[k] = amm_if_m[k].write;
    assign m_addr[k]  = amm_if_m[k].address;
    assign m_be[k]    = amm_if_m[k].byteenable;
    assign m_wdata[k] = amm_if_m[k].writedata;

    assign amm_if_m[k].waitrequest   = !(granted && (gnt_id_q == IdW'(k))) ||
                                       amm_if_s.waitrequest;
    assign amm_if_m[k].readdatavalid = rsp_valid && (fifo_dout == IdW'(k));
    assign amm_if_m[k].readdata      = amm_if_s.readdata;
  end

  assign granted  = (state_q == GRANT);
  // A full ID FIFO only holds back reads; writes need no return slot.
  assign eligible = m_write | (m_read & {M_CNT{!fifo_full}});

  assign amm_if_s.read       = granted && m_read[gnt_id_q];
  assign amm_if_s.write      = granted && m_write[gnt_id_q];
  assign amm_if_s.address    = m_addr[gnt_id_q];
  assign amm_if_s.byteenable = m_be[gnt_id_q];
  assign amm_if_s.writedata  = m_wdata[gnt_id_q];

  // A master that drops its request mid-grant keeps the grant until it re-asserts.
  assign accept    = granted && !amm_if_s.waitrequest &&
                     (m_read[gnt_id_q] || m_write[gnt_id_q]);
  assign push      = accept && m_read[gnt_id_q];
  assign rsp_valid = amm_if_s.readdatavalid && !fifo_empty;

`ifdef AMM_ARB_ROUND_ROBIN_EN
  logic [IdW-1:0] last_gnt_q;

  assign search_start = (last_gnt_q == IdW'(M_CNT - 1)) ? '0 : last_gnt_q + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_gnt_q <= IdW'(M_CNT - 1);
    end else if (state_q == IDLE && |eligible) begin
      last_gnt_q <= winner;
    end
  end
`else
  assign search_start = '0;
`endif

  assign winner = pick_winner(eligible, search_start);

  always_comb begin
    state_d  = state_q;
    gnt_id_d = gnt_id_q;
    unique case (state_q)
      IDLE: begin
        if (|eligible) begin
          state_d  = GRANT;
          gnt_id_d = winner;
        end
      end
      GRANT: begin
        if (accept) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      gnt_id_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_id_q <= gnt_id_d;
      if (amm_if_s.readdatavalid && fifo_empty) err_q <= 1'b1;
    end
  end

  assign err_o = err_q;

  amm_arb_id_fifo #(
    .DEPTH (MAX_RD),
    .ID_W  (IdW)
  ) u_id_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push),
    .pop   (amm_if_s.readdatavalid),
    .din   (gnt_id_q),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
endmodule

// File: tb/tb_amm_arbiter.sv
module tb_amm_arbiter;
  localparam int unsigned M_CNT  = 2;
  localparam int unsigned A_W    = 32;
  localparam int unsigned D_W    = 64;
  localparam int unsigned MAX_RD = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic             m_read  [M_CNT];
  logic             m_write [M_CNT];
  logic [A_W-1:0]   m_addr  [M_CNT];
  logic [D_W/8-1:0] m_be    [M_CNT];
  logic [D_W-1:0]   m_wdata [M_CNT];
  logic             m_wait  [M_CNT];
  logic             m_rdv   [M_CNT];
  logic [D_W-1:0]   m_rdata [M_CNT];

  logic             s_wait, s_rdv;
  logic [D_W-1:0]   s_rdata;
  logic             s_read, s_write;
  logic [A_W-1:0]   s_addr;
  logic [D_W/8-1:0] s_be;
  logic [D_W-1:0]   s_wdata;
  logic             err;

  amm_if #(.A_W(A_W), .D_W(D_W)) m_if [M_CNT] ();
  amm_if #(.A_W(A_W), .D_W(D_W)) s_if ();

  for (genvar k = 0; k < M_CNT; k++) begin : g_m
    assign m_if[k].read       = m_read[k];
    assign m_if[k].write      = m_write[k];
    assign m_if[k].address    = m_addr[k];
    assign m_if[k].byteenable = m_be[k];
    assign m_if[k].writedata  = m_wdata[k];
    assign m_wait[k]          = m_if[k].waitrequest;
    assign m_rdv[k]           = m_if[k].readdatavalid;
    assign m_rdata[k]         = m_if[k].readdata;
  end

  assign s_if.waitrequest   = s_wait;
  assign s_if.readdatavalid = s_rdv;
  assign s_if.readdata      = s_rdata;
  assign s_read             = s_if.read;
  assign s_write            = s_if.write;
  assign s_addr             = s_if.address;
  assign s_be               = s_if.byteenable;
  assign s_wdata            = s_if.writedata;

  amm_arbiter #(
    .M_CNT  (M_CNT),
    .A_W    (A_W),
    .D_W    (D_W),
    .MAX_RD (MAX_RD)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .amm_if_m (m_if),
    .amm_if_s (s_if),
    .err_o    (err)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;
  int exp_q[$];   // expected recipient of each outstanding read, issue order

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one slave read response and check it lands at the scoreboard head.
  task automatic return_rsp(input logic [D_W-1:0] data, input string name);
    int e;
    s_rdv   = 1'b1;
    s_rdata = data;
    #1;
    total_cnt++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s: response with no expected entry", name);
    end else begin
      e = exp_q.pop_front();
      if (m_rdv[e] !== 1'b1 || m_rdata[e] !== data || m_rdv[1-e] !== 1'b0)
        $display("FAIL %s: m%0d rdv=%b data=%h other_rdv=%b, want rdv=1 data=%h other=0",
                 name, e, m_rdv[e], m_rdata[e], m_rdv[1-e], data);
      else pass_cnt++;
    end
    tick();
    s_rdv = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      total_cnt++;
      if (m_wait[k] !== 1'b1) $display("FAIL reset_wait m%0d: got %b want 1", k, m_wait[k]);
      else pass_cnt++;
      total_cnt++;
      if (m_rdv[k] !== 1'b0) $display("FAIL reset_rdv m%0d: got %b want 0", k, m_rdv[k]);
      else pass_cnt++;
    end
    total_cnt++;
    if (s_read !== 1'b0 || s_write !== 1'b0 || err !== 1'b0)
      $display("FAIL reset_slave: rd=%b wr=%b err=%b want 0 0 0", s_read, s_write, err);
    else pass_cnt++;
  endtask

  task automatic test_contention();
    int exp_seq[4];
    int acc;
    logic [D_W-1:0] rd [4];
`ifdef AMM_ARB_ROUND_ROBIN_EN
    exp_seq = '{0, 1, 0, 1};
`else
    exp_seq = '{0, 0, 0, 0};
`endif
    rd = '{64'h11, 64'h22, 64'h33, 64'h44};
    m_addr[0] = 32'h1000;
    m_addr[1] = 32'h2000;
    m_read[0] = 1'b1;
    m_read[1] = 1'b1;
    s_wait    = 1'b0;
    acc       = 0;
    for (int cyc = 0; cyc < 24 && acc < 4; cyc++) begin
      tick();
      if (s_read && !s_wait) begin
        total_cnt++;
        if (m_wait[exp_seq[acc]] !== 1'b0 || m_wait[1-exp_seq[acc]] !== 1'b1)
          $display("FAIL contention_grant #%0d: wait m0=%b m1=%b, want m%0d granted",
                   acc, m_wait[0], m_wait[1], exp_seq[acc]);
        else pass_cnt++;
        total_cnt++;
        if (s_addr !== m_addr[exp_seq[acc]])
          $display("FAIL contention_addr #%0d: got %h want %h", acc, s_addr,
                   m_addr[exp_seq[acc]]);
        else pass_cnt++;
        exp_q.push_back(exp_seq[acc]);
        acc++;
      end
    end
    total_cnt++;
    if (acc != 4) $display("FAIL contention_accepts: got %0d want 4", acc);
    else pass_cnt++;
    tick();
    m_read[0] = 1'b0;
    m_read[1] = 1'b0;
    for (int j = 0; j < 4; j++) return_rsp(rd[j], "contention_rsp");
  endtask

  task automatic test_single_write();
    m_write[0] = 1'b1;
    m_addr[0]  = 32'h100;
    m_wdata[0] = 64'hA5;
    m_be[0]    = 8'hFF;
    s_wait     = 1'b0;
    #1;
    total_cnt++;
    if (s_write !== 1'b0) $display("FAIL write_arb_cycle: s_write=%b want 0", s_write);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (s_write !== 1'b1 || s_addr !== 32'h100 || s_wdata !== 64'hA5 || s_be !== 8'hFF)
      $display("FAIL write_cmd: wr=%b addr=%h data=%h be=%h want 1 100 a5 ff",
               s_write, s_addr, s_wdata, s_be);
    else pass_cnt++;
    total_cnt++;
    if (m_wait[0] !== 1'b0 || m_wait[1] !== 1'b1)
      $display("FAIL write_wait: m0=%b m1=%b want 0 1", m_wait[0], m_wait[1]);
    else pass_cnt++;
    tick();
    m_write[0] = 1'b0;
    #1;
    total_cnt++;
    if (s_write !== 1'b0 || m_wait[0] !== 1'b1)
      $display("FAIL write_done: s_write=%b m0_wait=%b want 0 1", s_write, m_wait[0]);
    else pass_cnt++;
  endtask

  task automatic test_wait_hold();
    m_write[0] = 1'b1;
    m_addr[0]  = 32'hA000;
    m_wdata[0] = 64'hDEAD_BEEF_0000_0001;
    s_wait     = 1'b1;
    tick();
    m_write[1] = 1'b1;
    m_addr[1]  = 32'hB000;
    m_wdata[1] = 64'h2;
    #1;
    for (int i = 0; i < 5; i++) begin
      total_cnt++;
      if (s_write !== 1'b1 || s_addr !== 32'hA000 || s_wdata !== 64'hDEAD_BEEF_0000_0001 ||
          m_wait[0] !== 1'b1 || m_wait[1] !== 1'b1)
        $display("FAIL wait_hold cyc%0d: wr=%b addr=%h data=%h w0=%b w1=%b want 1 a000 .. 1 1",
                 i, s_write, s_addr, s_wdata, m_wait[0], m_wait[1]);
      else pass_cnt++;
      tick();
    end
    s_wait = 1'b0;
    #1;
    total_cnt++;
    if (m_wait[0] !== 1'b0) $display("FAIL wait_release: m0_wait=%b want 0", m_wait[0]);
    else pass_cnt++;
    tick();
    m_write[0] = 1'b0;
    tick();
    total_cnt++;
    if (s_write !== 1'b1 || s_addr !== 32'hB000 || m_wait[1] !== 1'b0)
      $display("FAIL wait_next: wr=%b addr=%h w1=%b want 1 b000 0", s_write, s_addr, m_wait[1]);
    else pass_cnt++;
    tick();
    m_write[1] = 1'b0;
  endtask

  task automatic test_drop();
    m_write[0] = 1'b1;
    m_addr[0]  = 32'hC000;
    s_wait     = 1'b1;
    tick();
    m_write[0] = 1'b0;
    #1;
    total_cnt++;
    if (s_write !== 1'b0) $display("FAIL drop_follow: s_write=%b want 0", s_write);
    else pass_cnt++;
    s_wait = 1'b0;
    tick();
    m_write[0] = 1'b1;
    #1;
    total_cnt++;
    if (s_write !== 1'b1 || m_wait[0] !== 1'b0)
      $display("FAIL drop_keep_grant: wr=%b w0=%b want 1 0", s_write, m_wait[0]);
    else pass_cnt++;
    tick();
    m_write[0] = 1'b0;
    tick();
  endtask

  task automatic test_fifo_full();
    int acc;
    m_addr[0] = 32'h3000;
    m_read[0] = 1'b1;
    s_wait    = 1'b0;
    acc       = 0;
    for (int cyc = 0; cyc < 40 && acc < 8; cyc++) begin
      tick();
      if (s_read && !s_wait) begin
        exp_q.push_back(0);
        acc++;
      end
    end
    total_cnt++;
    if (acc != 8) $display("FAIL full_accepts: got %0d want 8", acc);
    else pass_cnt++;
    tick();
    m_write[1] = 1'b1;
    m_addr[1]  = 32'h4000;
    tick();
    total_cnt++;
    if (s_write !== 1'b1 || s_read !== 1'b0 || m_wait[1] !== 1'b0 || m_wait[0] !== 1'b1)
      $display("FAIL full_write_granted: wr=%b rd=%b w1=%b w0=%b want 1 0 0 1",
               s_write, s_read, m_wait[1], m_wait[0]);
    else pass_cnt++;
    tick();
    m_write[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (s_read !== 1'b0 || m_wait[0] !== 1'b1)
        $display("FAIL full_blocks_read cyc%0d: rd=%b w0=%b want 0 1", i, s_read, m_wait[0]);
      else pass_cnt++;
      tick();
    end
    return_rsp(64'hF0, "full_first_rsp");
    acc = 0;
    for (int cyc = 0; cyc < 6 && acc < 1; cyc++) begin
      if (s_read && !s_wait) begin
        exp_q.push_back(0);
        acc++;
      end
      tick();
    end
    m_read[0] = 1'b0;
    total_cnt++;
    if (acc != 1) $display("FAIL full_reenable: got %0d accepts want 1", acc);
    else pass_cnt++;
    for (int j = 0; j < 8; j++) return_rsp(64'h100 + 64'(j), "full_drain_rsp");
    total_cnt++;
    if (err !== 1'b0) $display("FAIL full_err: got %b want 0", err);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int acc;
    m_addr[0] = 32'h5000;
    m_read[0] = 1'b1;
    s_wait    = 1'b0;
    acc       = 0;
    for (int cyc = 0; cyc < 20 && acc < 3; cyc++) begin
      tick();
      if (s_read && !s_wait) acc++;
    end
    tick();
    s_wait = 1'b1;
    tick();
    total_cnt++;
    if (acc != 3 || s_read !== 1'b1)
      $display("FAIL rstmid_setup: accepts=%0d rd=%b want 3 1", acc, s_read);
    else pass_cnt++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    #1;
    total_cnt++;
    if (s_read !== 1'b0 || m_wait[0] !== 1'b1 || err !== 1'b0)
      $display("FAIL rstmid_idle: rd=%b w0=%b err=%b want 0 1 0", s_read, m_wait[0], err);
    else pass_cnt++;
    m_read[0] = 1'b0;
    s_wait    = 1'b0;
    s_rdv     = 1'b1;
    s_rdata   = 64'h77;
    #1;
    total_cnt++;
    if (m_rdv[0] !== 1'b0 || m_rdv[1] !== 1'b0)
      $display("FAIL rstmid_stray_rdv: m0=%b m1=%b want 0 0", m_rdv[0], m_rdv[1]);
    else pass_cnt++;
    tick();
    s_rdv = 1'b0;
    total_cnt++;
    if (err !== 1'b1) $display("FAIL rstmid_err_set: got %b want 1", err);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (err !== 1'b1) $display("FAIL rstmid_err_sticky: got %b want 1", err);
    else pass_cnt++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total_cnt++;
    if (err !== 1'b0) $display("FAIL rstmid_err_clear: got %b want 0", err);
    else pass_cnt++;
  endtask

  initial begin
    for (int k = 0; k < M_CNT; k++) begin
      m_read[k]  = 1'b0;
      m_write[k] = 1'b0;
      m_addr[k]  = '0;
      m_be[k]    = '1;
      m_wdata[k] = '0;
    end
    s_wait  = 1'b0;
    s_rdv   = 1'b0;
    s_rdata = '0;
    test_reset();
    test_contention();
    test_single_write();
    test_wait_hold();
    test_drop();
    test_fifo_full();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
